knn_vote: RTL and testbench

Downstream classification stage for the `knn` solver array. Once the array has finished streaming the dataset, this block walks every solver's `HW_K` neighbour registers through the `SOLVER_SEL`/`SEL`/`DATA_OUT` readout port and extracts a class label from each entry. It computes a majority vote per solver and emits one classified result per solver over a valid/ready handshake to the CPU-side register bank.

---
 rtl/knn_vote.sv | 200 ++++++++++++++++++++
 tb/tb_knn_vote.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// Majority-vote classifier that walks every knn solver's neighbour registers
// and emits one (solver, label, votes) result per solver over valid/ready.
module knn_vote #(
  parameter int HW_K      = 10,
  parameter int N_SOLVERS = 4,
  parameter int DATA_W    = 16,
  parameter int N_CLASSES = 10,
  parameter int LABEL_W   = 4,
  parameter int VOTE_W    = $clog2(HW_K + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic [15:0]        SOLVER_SEL,
  output logic [15:0]        SEL,
  input  logic [DATA_W-1:0]  DATA_OUT,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [15:0]        result_solver,
  output logic [LABEL_W-1:0] result_label,
  output logic [VOTE_W-1:0]  result_votes,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, CLEAR, READ, SCAN, EMIT} state_t;

  state_t               state_q, state_d;
  logic [15:0]          solver_q, solver_d;
  logic [15:0]          sel_q, sel_d;
  logic [LABEL_W-1:0]   scan_q, scan_d;
  logic [LABEL_W-1:0]   best_label_q, best_label_d;
  logic [VOTE_W-1:0]    best_votes_q, best_votes_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [15:0]          res_solver_q, res_solver_d;
  logic [LABEL_W-1:0]   res_label_q, res_label_d;
  logic [VOTE_W-1:0]    res_votes_q, res_votes_d;

  logic [N_CLASSES-1:0][VOTE_W-1:0] count_all;

  logic [LABEL_W-1:0] label;
  logic               label_ok;
  logic               data_unused;

  assign label       = DATA_OUT[LABEL_W-1:0];
  assign label_ok    = {1'b0, label} < (LABEL_W + 1)'(N_CLASSES);
  assign data_unused = ^DATA_OUT[DATA_W-1:LABEL_W];

  // One vote counter per class; out-of-range labels match no counter.
  genvar gi;
  generate
    for (gi = 0; gi < N_CLASSES; gi++) begin : g_cnt
      logic [VOTE_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (state_q == CLEAR) begin
          cnt_d = '0;
        end else if (state_q == READ && label_ok && label == LABEL_W'(gi)) begin
          cnt_d = cnt_q + VOTE_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign count_all[gi] = cnt_q;
    end
  endgenerate

  logic [VOTE_W-1:0]  scan_cnt;
  logic [LABEL_W-1:0] scan_label;
  logic [VOTE_W-1:0]  scan_votes;

  always_comb begin
    scan_cnt   = count_all[scan_q];
    scan_label = best_label_q;
    scan_votes = best_votes_q;
    // Strict compare keeps the earliest (lowest) label on ties.
    if (scan_cnt > best_votes_q) begin
      scan_label = scan_q;
      scan_votes = scan_cnt;
    end
  end

  always_comb begin
    state_d      = state_q;
    solver_d     = solver_q;
    sel_d        = sel_q;
    scan_d       = scan_q;
    best_label_d = best_label_q;
    best_votes_d = best_votes_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    res_solver_d = res_solver_q;
    res_label_d  = res_label_q;
    res_votes_d  = res_votes_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CLEAR;
          busy_d   = 1'b1;
          solver_d = '0;
        end
      end
      CLEAR: begin
        sel_d        = '0;
        scan_d       = '0;
        best_label_d = '0;
        best_votes_d = '0;
        state_d      = READ;
      end
      READ: begin
        if (sel_q == 16'(HW_K - 1)) begin
          sel_d   = '0;
          state_d = SCAN;
        end else begin
          sel_d = sel_q + 16'd1;
        end
      end
      SCAN: begin
        best_label_d = scan_label;
        best_votes_d = scan_votes;
        if (scan_q == LABEL_W'(N_CLASSES - 1)) begin
          state_d      = EMIT;
          valid_d      = 1'b1;
          res_solver_d = solver_q;
          res_label_d  = scan_label;
          res_votes_d  = scan_votes;
        end else begin
          scan_d = scan_q + LABEL_W'(1);
        end
      end
      EMIT: begin
        if (result_ready) begin
          valid_d = 1'b0;
          if (solver_q < 16'(N_SOLVERS - 1)) begin
            solver_d = solver_q + 16'd1;
            state_d  = CLEAR;
          end else begin
            solver_d     = '0;
            state_d      = IDLE;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            res_solver_d = '0;
            res_label_d  = '0;
            res_votes_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      solver_q     <= '0;
      sel_q        <= '0;
      scan_q       <= '0;
      best_label_q <= '0;
      best_votes_q <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      res_solver_q <= '0;
      res_label_q  <= '0;
      res_votes_q  <= '0;
    end else begin
      state_q      <= state_d;
      solver_q     <= solver_d;
      sel_q        <= sel_d;
      scan_q       <= scan_d;
      best_label_q <= best_label_d;
      best_votes_q <= best_votes_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      res_solver_q <= res_solver_d;
      res_label_q  <= res_label_d;
      res_votes_q  <= res_votes_d;
    end
  end

  assign busy          = busy_q;
  assign SOLVER_SEL    = solver_q;
  assign SEL           = sel_q;
  assign result_valid  = valid_q;
  assign result_solver = res_solver_q;
  assign result_label  = res_label_q;
  assign result_votes  = res_votes_q;
  assign done          = done_q;

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: a label table models the knn readout port and
// expected per-solver votes are queued at start, then popped on each result.
module tb_knn_vote;
  localparam int HW_K = 10;
  localparam int NS   = 4;
  localparam int NC   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        result_ready = 1'b0;
  logic        busy, result_valid, done;
  logic [15:0] solver_sel, sel, result_solver;
  logic [15:0] data_out;
  logic [3:0]  result_label;
  logic [3:0]  result_votes;

  logic [3:0]  lab [NS][HW_K];

  typedef struct {
    int s;
    int label;
    int votes;
  } exp_t;
  exp_t sbq[$];

  int total = 0;
  int bad   = 0;

  knn_vote dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .SOLVER_SEL(solver_sel), .SEL(sel), .DATA_OUT(data_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_solver(result_solver), .result_label(result_label),
    .result_votes(result_votes), .done(done)
  );

  always #5 clk = ~clk;

  // Readout model: upper bits are junk so the label mask is exercised.
  always_comb begin
    data_out = 16'hFFFF;
    if (solver_sel < 16'(NS) && sel < 16'(HW_K))
      data_out = {12'hABC, lab[solver_sel[1:0]][sel[3:0]]};
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int s);
    int   cnt [NC];
    exp_t e;
    foreach (cnt[i]) cnt[i] = 0;
    for (int k = 0; k < HW_K; k++)
      if (int'(lab[s][k]) < NC) cnt[lab[s][k]]++;
    e.s = s;
    e.label = 0;
    e.votes = 0;
    for (int c = 0; c < NC; c++)
      if (cnt[c] > e.votes) begin
        e.label = c;
        e.votes = cnt[c];
      end
    return e;
  endfunction

  task automatic check_result(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    $display("%s result solver=%0d label=%0d votes=%0d (exp %0d/%0d/%0d)", name,
             result_solver, result_label, result_votes, e.s, e.label, e.votes);
    chk("result_solver", int'(result_solver), e.s);
    chk("result_label", int'(result_label), e.label);
    chk("result_votes", int'(result_votes), e.votes);
    chk("solver_sel_emit", int'(solver_sel), e.s);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!result_valid && n < 200) begin
      step();
      n++;
    end
    chk("latency", n, 21);
  endtask

  task automatic run_job(input int hold, input string name);
    for (int s = 0; s < NS; s++) sbq.push_back(model(s));
    result_ready = (hold == 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int s = 0; s < NS; s++) begin
      wait_valid();
      check_result(name);
      if (hold > 0) begin
        logic [15:0] ss, rs;
        logic [3:0]  rl, rv;
        ss = solver_sel; rs = result_solver; rl = result_label; rv = result_votes;
        start = 1'b1;
        for (int h = 0; h < hold; h++) begin
          step();
          chk("hold_valid", int'(result_valid), 1);
          chk("hold_solver_sel", int'(solver_sel), int'(ss));
          chk("hold_result_solver", int'(result_solver), int'(rs));
          chk("hold_label", int'(result_label), int'(rl));
          chk("hold_votes", int'(result_votes), int'(rv));
        end
        start = 1'b0;
        result_ready = 1'b1;
      end
      if (s == NS - 1) start = 1'b1;
      step();
      if (hold > 0) result_ready = 1'b0;
      chk("valid_drop", int'(result_valid), 0);
      if (s < NS - 1) begin
        chk("solver_sel_adv", int'(solver_sel), s + 1);
        chk("busy_mid", int'(busy), 1);
        chk("done_mid", int'(done), 0);
      end else begin
        chk("done_pulse", int'(done), 1);
        chk("busy_fall", int'(busy), 0);
        chk("solver_sel_idle", int'(solver_sel), 0);
        start = 1'b0;
        step();
        chk("done_once", int'(done), 0);
        chk("no_restart", int'(busy), 0);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_valid"}, int'(result_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_solver_sel"}, int'(solver_sel), 0);
    chk({tag, "_sel"}, int'(sel), 0);
    chk({tag, "_rsolver"}, int'(result_solver), 0);
    chk({tag, "_label"}, int'(result_label), 0);
    chk({tag, "_votes"}, int'(result_votes), 0);
  endtask

  initial begin
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < HW_K; k++) lab[s][k] = 4'd0;
    repeat (2) step();
    check_zero("reset");
    rst = 1'b0;
    step();
    check_zero("idle");

    // Job 1: unanimous, tie, all-out-of-range, mixed tie with junk labels.
    for (int k = 0; k < HW_K; k++) begin
      lab[0][k] = 4'd3;
      lab[1][k] = k[0] ? 4'd7 : 4'd2;
      lab[2][k] = 4'd12;
    end
    lab[3] = '{4'd9, 4'd15, 4'd9, 4'd1, 4'd1, 4'd9, 4'd13, 4'd0, 4'd1, 4'd11};
    run_job(0, "mixed");

    // Job 2: label s+1 on every solver, ready held high.
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < HW_K; k++) lab[s][k] = 4'(s + 1);
    run_job(0, "s_plus_1");

    // Job 3: random labels under backpressure.
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < HW_K; k++) lab[s][k] = 4'($urandom_range(0, 15));
    run_job(4, "backpressure");

    // Reset during solver 1 readout, then a clean job.
    for (int s = 0; s < NS; s++)
      for (int k = 0; k < HW_K; k++) lab[s][k] = 4'($urandom_range(0, 11));
    sbq.push_back(model(0));
    result_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid();
    check_result("pre_rst");
    step();
    repeat (5) step();
    chk("in_read_sel", int'(sel), 4);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    #3 rst = 1'b0;
    sbq.delete();
    step();
    check_zero("post_rst_idle");
    run_job(0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
